seven_seg_mux: RTL and testbench

//  Parametrised multiplexed 7-segment display driver. Accepts a binary word on a

---
 rtl/seven_seg_mux.sv | 205 ++++++++++++++++++++
 tb/tb_seven_seg_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: multiplexed common-anode 7-segment driver with
// sequential binary-to-BCD conversion, blanking, dp and overflow.
module seven_seg_mux #(
    parameter int DIGITS    = 4,
    parameter int DIV_RATIO = 100,
    parameter int DIN_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              hex_mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic [DIGITS-1:0] digit_sel,
    output logic [6:0]        seg_out,
    output logic              dp_out
);

    localparam int NB    = (DIN_W * 30103) / 100000 + 2;
    localparam int BCD_W = 4 * NB;
    localparam int DW    = 4 * DIGITS;
    localparam int XW    = (BCD_W > DW) ? BCD_W : DW;
    localparam int CW    = $clog2(DIN_W + 1);
    localparam int VW    = $clog2(DIV_RATIO);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t            state, state_n;
    logic              accept, latch;
    logic [DIN_W-1:0]  sh;
    logic [BCD_W-1:0]  bcd, bcd_adj;
    logic [CW-1:0]     cnt;
    logic              mode_q, blz_q;
    logic [DIGITS-1:0] dp_q;

    logic [XW-1:0]     src;
    logic              new_ovf, seen;
    logic [DIGITS-1:0] new_blank;

    logic [DW-1:0]     disp_dig, cur_dig;
    logic [DIGITS-1:0] disp_blank, disp_dp, cur_blank, cur_dp;
    logic              disp_ovf, disp_valid, cur_ovf, valid_n;

    logic [VW-1:0]     div, div_n;
    logic [IW-1:0]     idx, idx_n;
    logic              div_wrap;
    logic [3:0]        nib;
    logic [DIGITS-1:0] sel_n;
    logic [6:0]        seg_n;
    logic              dpo_n;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign din_ready = (state == IDLE);
    assign accept    = din_valid && din_ready;
    assign latch     = (state == LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = hex_mode ? LATCH : CONV;
            CONV:    if (cnt == CW'(DIN_W - 1)) state_n = LATCH;
            LATCH:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // shift-add-3: correct every nibble before the next bit enters
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            bcd    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            blz_q  <= 1'b0;
            dp_q   <= '0;
        end else if (accept) begin
            sh     <= din;
            bcd    <= '0;
            cnt    <= '0;
            mode_q <= hex_mode;
            blz_q  <= blank_lz;
            dp_q   <= dp_in;
        end else if (state == CONV) begin
            sh  <= sh << 1;
            bcd <= BCD_W'({bcd_adj, sh[DIN_W-1]});
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        src = '0;
        if (mode_q) src[DIN_W-1:0] = sh;
        else        src[BCD_W-1:0] = bcd;
        new_ovf   = (src >> DW) != '0;
        seen      = 1'b0;
        new_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen         = seen | (src[4*i +: 4] != 4'd0) | (i == 0);
            new_blank[i] = blz_q & ~seen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_dig   <= '0;
            disp_blank <= '0;
            disp_dp    <= '0;
            disp_ovf   <= 1'b0;
            disp_valid <= 1'b0;
        end else if (latch) begin
            disp_dig   <= src[DW-1:0];
            disp_blank <= new_blank;
            disp_dp    <= dp_q;
            disp_ovf   <= new_ovf;
            disp_valid <= 1'b1;
        end
    end

    // bypass so the pins switch on the same edge the register commits
    assign cur_dig   = latch ? src[DW-1:0] : disp_dig;
    assign cur_blank = latch ? new_blank   : disp_blank;
    assign cur_dp    = latch ? dp_q        : disp_dp;
    assign cur_ovf   = latch ? new_ovf     : disp_ovf;
    assign valid_n   = latch | disp_valid;

    assign div_wrap = (div == VW'(DIV_RATIO - 1));

    always_comb begin
        div_n = div_wrap ? '0 : div + 1'b1;
        idx_n = idx;
        if (div_wrap)
            idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    always_comb begin
        nib   = cur_dig[4*idx_n +: 4];
        sel_n = '1;
        seg_n = 7'b1111111;
        dpo_n = 1'b1;
        if (valid_n) begin
            sel_n = ~(DIGITS'(1) << idx_n);
            if (cur_ovf) begin
                seg_n = 7'b1111110;
            end else begin
                seg_n = cur_blank[idx_n] ? 7'b1111111 : seg_decode(nib);
                dpo_n = ~cur_dp[idx_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            idx       <= '0;
            digit_sel <= '1;
            seg_out   <= 7'b1111111;
            dp_out    <= 1'b1;
        end else begin
            div       <= div_n;
            idx       <= idx_n;
            digit_sel <= sel_n;
            seg_out   <= seg_n;
            dp_out    <= dpo_n;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: randomized bench with an arithmetic display
// model and a scan-position model derived from cycle count.
`timescale 1ns/1ps
module tb_seven_seg_mux;

    localparam int D1 = 4, R1 = 5, W1 = 14;
    localparam int D2 = 6, R2 = 4, W2 = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W1-1:0] din = '0;
    logic          din_valid = 1'b0, hex_mode = 1'b0, blank_lz = 1'b0;
    logic [D1-1:0] dp_in = '0;
    logic          din_ready, dp_out;
    logic [D1-1:0] digit_sel;
    logic [6:0]    seg_out;

    logic [W2-1:0] b_din = '0;
    logic          b_valid = 1'b0, b_hex = 1'b0, b_blz = 1'b0;
    logic [D2-1:0] b_dp = '0;
    logic          b_ready, b_dpo;
    logic [D2-1:0] b_sel;
    logic [6:0]    b_seg;

    seven_seg_mux #(.DIGITS(D1), .DIV_RATIO(R1), .DIN_W(W1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .dp_in(dp_in), .digit_sel(digit_sel), .seg_out(seg_out),
        .dp_out(dp_out)
    );

    seven_seg_mux #(.DIGITS(D2), .DIV_RATIO(R2), .DIN_W(W2)) dut6 (
        .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_valid),
        .din_ready(b_ready), .hex_mode(b_hex), .blank_lz(b_blz),
        .dp_in(b_dp), .digit_sel(b_sel), .seg_out(b_seg),
        .dp_out(b_dpo)
    );

    int n_chk = 0;
    int n_fail = 0;
    int unsigned ecnt;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    logic [6:0] font [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    bit         exp_valid = 1'b0;
    logic [6:0] exp_seg [D1];
    logic       exp_dp  [D1];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model(input int v, input bit hx, input bit blz,
                         input logic [D1-1:0] dp);
        int d [D1];
        int top, p;
        bit ovf;
        top = 0;
        p = 1;
        for (int i = 0; i < D1; i++) begin
            d[i] = hx ? ((v >> (4*i)) & 15) : ((v / p) % 10);
            p = p * 10;
            if (d[i] != 0) top = i;
        end
        ovf = hx ? ((v >> (4*D1)) != 0) : (v >= p);
        for (int i = 0; i < D1; i++) begin
            if (ovf)                exp_seg[i] = 7'b1111110;
            else if (blz && i > top) exp_seg[i] = 7'b1111111;
            else                    exp_seg[i] = font[d[i]];
            exp_dp[i] = ovf ? 1'b1 : ~dp[i];
        end
        exp_valid = 1'b1;
    endtask

    task automatic check_disp();
        int k;
        logic [D1-1:0] es;
        if (!exp_valid) begin
            check("sel_idle", 32'(digit_sel), 32'hF);
            check("seg_idle", 32'(seg_out), 32'h7F);
            check("dp_idle", 32'(dp_out), 32'h1);
        end else begin
            k = int'((ecnt / R1) % D1);
            es = '1;
            es[k] = 1'b0;
            check("sel", 32'(digit_sel), 32'(es));
            check("seg", 32'(seg_out), 32'(exp_seg[k]));
            check("dp", 32'(dp_out), 32'(exp_dp[k]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(din_ready), 32'h1);
        check("rst_sel", 32'(digit_sel), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_sel6", 32'(b_sel), 32'h3F);
        repeat (3) @(negedge clk);
        check("rst_hold_sel", 32'(digit_sel), 32'hF);
        rst_n = 1'b1;
        exp_valid = 1'b0;
    endtask

    task automatic send(input int v, input bit hx, input bit blz,
                        input logic [D1-1:0] dp, input bit hold);
        int n;
        n = 0;
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(din_ready), 32'h1);
        din = W1'(v);
        din_valid = 1'b1;
        hex_mode = hx;
        blank_lz = blz;
        dp_in = dp;
        @(negedge clk);
        din_valid = hold;
        n = 0;
        while (!din_ready && n < 100) begin
            check_disp();
            if (hold) begin
                din = W1'($urandom);
                hex_mode = 1'($urandom);
                blank_lz = 1'($urandom);
                dp_in = D1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        din_valid = 1'b0;
        check("latency", 32'(n), hx ? 32'd1 : 32'(W1 + 1));
        model(v, hx, blz, dp);
        repeat (D1 * R1 + 2) begin
            check_disp();
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v, k;
        bit hx, blz;
        logic [D1-1:0] dp;
        logic [D2-1:0] es6;

        @(negedge clk);
        do_reset();
        repeat (6) begin
            check_disp();
            @(negedge clk);
        end

        b_din = 24'h123456;
        b_hex = 1'b1;
        b_dp = 6'b000001;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        @(negedge clk);
        repeat (2 * D2 * R2 + 2) begin
            k = int'((ecnt / R2) % D2);
            es6 = '1;
            es6[k] = 1'b0;
            check("scan_sel", 32'(b_sel), 32'(es6));
            check("scan_seg", 32'(b_seg), 32'(font[6 - k]));
            check("scan_dp", 32'(b_dpo), (k == 0) ? 32'h0 : 32'h1);
            @(negedge clk);
        end

        send(1234, 1'b0, 1'b0, 4'b0000, 1'b0);
        do_reset();
        send(7, 1'b0, 1'b1, 4'b0010, 1'b0);
        send(0, 1'b0, 1'b1, 4'b0000, 1'b0);
        send(32'h2BEF, 1'b1, 1'b0, 4'b0000, 1'b0);
        send(12000, 1'b0, 1'b0, 4'b1111, 1'b0);
        send(9999, 1'b0, 1'b1, 4'b0001, 1'b0);
        send(10000, 1'b0, 1'b1, 4'b0000, 1'b0);
        send(4321, 1'b0, 1'b0, 4'b0100, 1'b1);
        send(32'h000A, 1'b1, 1'b1, 4'b1000, 1'b0);
        send(32'h0C0D, 1'b1, 1'b1, 4'b0000, 1'b1);

        din = 14'd9876;
        hex_mode = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("conv_busy", 32'(din_ready), 32'h0);
        do_reset();
        repeat (2 * W1) begin
            check_disp();
            @(negedge clk);
        end
        send(5678, 1'b0, 1'b0, 4'b0000, 1'b0);

        repeat (24) begin
            hx = 1'($urandom);
            blz = 1'($urandom);
            dp = D1'($urandom);
            if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 99));
            else                           v = int'($urandom_range(0, 16383));
            send(v, hx, blz, dp, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
